uart_ctrl: RTL
==============

Name: uart_ctrl

Overview:
- Serial UART engine directly downstream and upstream of the data memory's MMIO block.
- Consumes the TX byte written at 0x40000018 and serialises it onto uart_tx.
- Deserialises uart_rx into the byte the memory returns at 0x4000001C.
- Produces the 5-bit status word returned at 0x40000020.
- Format is fixed 8N1, LSB first. One TX holding byte, one RX holding byte.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); must be >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low; when 0 at a clk edge all state returns to reset values
- tx_data  input  8  byte to transmit (MMIO write data [7:0])
- tx_start  input  1  one-cycle strobe: CPU wrote 0x40000018
- rx_read  input  1  one-cycle strobe: CPU read 0x4000001C
- con_read  input  1  one-cycle strobe: CPU read 0x40000020
- uart_rx  input  1  asynchronous serial input, idle high
- uart_tx  output  1  serial output, idle high
- rx_data  output  8  last good received byte
- uart_con  output  5  status word: [0] rx_valid, [1] rx_overrun, [2] tx_busy, [3] tx_done, [4] rx_frame_err

Behaviour:

Reset values:
- uart_tx = 1, rx_data = 0, uart_con = 0.
- Both FSMs in IDLE; all counters at 0.
- The RX synchroniser flops reset to 1.

TX FSM (states IDLE, START, DATA, STOP):
- IDLE, tx_start = 1: latch tx_data into the shift register, go to START, assert tx_busy on the next cycle.
- tx_start in any state other than IDLE is ignored; the latched byte is unchanged.
- START: uart_tx = 0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: uart_tx = 1 for CLKS_PER_BIT cycles, then return to IDLE.
- On return to IDLE, tx_busy clears and tx_done sets in the same cycle.
- uart_tx first goes low 1 cycle after the accepted strobe.
- A frame lasts exactly 10*CLKS_PER_BIT cycles.
- A tx_start arriving in the cycle the FSM re-enters IDLE is accepted on the following cycle only if still asserted; strobes are not queued.

RX path:
- uart_rx passes through a 2-flop synchroniser; the FSM sees rx_s, 2 cycles late.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s = 0 goes to START.
- START: wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - If 1, treat as a glitch and return to IDLE; no flag is set.
  - If 0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles (bit centres) and shift in LSB first, 8 samples.
- STOP: sample after CLKS_PER_BIT cycles.
- Stop bit = 1: rx_data is updated with the byte and rx_valid sets, both in the same cycle. If rx_valid was already 1, rx_overrun also sets; the new byte replaces the old. Return to IDLE.
- Stop bit = 0: rx_frame_err sets, rx_data is unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE (a break condition cannot retrigger reception).

Flag clearing:
- rx_read clears rx_valid.
- con_read clears rx_overrun, tx_done and rx_frame_err.
- tx_busy and rx_valid are not cleared by con_read.
- Set has priority over clear in the same cycle: a byte completing while rx_read = 1 leaves rx_valid = 1 with no overrun. Likewise for tx_done or the error flags against con_read.

Reset mid-operation:
- reset low mid-frame aborts both FSMs at that edge and forces uart_tx = 1 and all flags to 0.
- A partially received byte is discarded.

Arithmetic:
- Bit counters are 3-bit; baud counters are sized by $clog2(CLKS_PER_BIT).
- The half-bit count uses integer division (CLKS_PER_BIT/2 rounds down).

Test Plan:
(All scenarios use CLKS_PER_BIT = 4.)
- TX frame: tx_data = 8'hA5 with a 1-cycle tx_start.
  - Required: uart_tx low from cycle +1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  - tx_busy high for 40 cycles; tx_done = 1 at cycle +41.
- TX busy: second tx_start with 8'h3C at cycle +10.
  - Required: frame remains 8'hA5, no second frame follows, tx_done set once.
- RX good byte: drive 8'h5A as 8N1 on uart_rx.
  - Required: rx_data = 8'h5A and uart_con = 5'b00001 after the stop sample.
  - rx_read pulse then gives uart_con[0] = 0, with rx_data still 8'h5A.
- RX overrun: send 8'h11 then 8'h22 with no rx_read.
  - Required: rx_data = 8'h22, uart_con[1:0] = 2'b11.
  - con_read clears [1] only.
- Frame error and glitch:
  - Byte with stop bit = 0 gives uart_con[4] = 1 with rx_data unchanged; holding the line low produces no further frames.
  - A 1-cycle low pulse on uart_rx gives no flags.
- Reset mid-frame: reset = 0 for 1 cycle at cycle +15 of a TX frame.
  - Required: uart_tx = 1 and uart_con = 0 on the next cycle, and no further bits are transmitted.

Source files
------------

// File: rtl/uart_ctrl.sv
// Fixed-format 8N1 UART engine behind the MMIO block: one TX holding byte, one RX holding byte,
// and a 5-bit sticky status word {rx_frame_err, tx_done, tx_busy, rx_overrun, rx_valid}.
module uart_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       rx_read,
    input  logic       con_read,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic [4:0] uart_con
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_line_q, tx_line_d;
    logic            tx_done_set;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_meta_q, rx_s_q;
    logic            rx_good, rx_bad;

    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ovr_q, rx_ovr_d;
    logic            tx_done_q, tx_done_d;
    logic            rx_ferr_q, rx_ferr_d;

    // TX: the line level is registered alongside the state so uart_tx is glitch-free.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_line_d   = tx_line_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (tx_start) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxStop: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_done_set = 1'b1;
                    tx_state_d  = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // RX: the start bit is re-checked at its centre, then every bit is sampled one period later.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (!rx_s_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_good    = rx_s_q;
                    rx_bad     = !rx_s_q;
                    rx_state_d = rx_s_q ? RxIdle : RxWaitHigh;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxWaitHigh: begin
                if (rx_s_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear wins. A byte landing while the old one is
    // being read is not an overrun.
    always_comb begin
        rx_data_d  = rx_good ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_good | (rx_valid_q & ~rx_read);
        rx_ovr_d   = (rx_good & rx_valid_q & ~rx_read) | (rx_ovr_q & ~con_read);
        tx_done_d  = tx_done_set | (tx_done_q & ~con_read);
        rx_ferr_d  = rx_bad | (rx_ferr_q & ~con_read);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= uart_rx;
            rx_s_q     <= rx_meta_q;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_done_q  <= tx_done_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign uart_tx  = tx_line_q;
    assign rx_data  = rx_data_q;
    assign uart_con = {rx_ferr_q, tx_done_q, tx_state_q != TxIdle, rx_ovr_q, rx_valid_q};

endmodule
